hazard_stall_unit: RTL
======================

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 2: EX-stage occupancy in cycles of a mult (opcode 0, funct 4); legal range 1..15.
REQ-002 SHALL provide parameter DIV_CYCLES, default 8: EX-stage occupancy in cycles of a div (opcode 0, funct 5); legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port IFIDIR, input, 16 bits: instruction in IF/ID.
REQ-006 SHALL have port IDEXIR, input, 16 bits: instruction in ID/EX.
REQ-007 SHALL have port Flush, input, 1 bit: taken-branch flush of IF/ID this cycle.
REQ-008 SHALL have port PCWrite, output, 1 bit: 1 lets the PC update.
REQ-009 SHALL have port IFIDWrite, output, 1 bit: 1 lets IF/ID load.
REQ-010 SHALL have port IDEXWrite, output, 1 bit: 1 lets ID/EX load.
REQ-011 SHALL have port IDEXBubble, output, 1 bit: 1 loads a NOP into ID/EX.
REQ-012 SHALL have port EXMEMBubble, output, 1 bit: 1 loads a NOP into EX/MEM.
REQ-013 SHALL have port MDBusy, output, 1 bit: a mult or div is occupying EX.

Function
REQ-014 SHALL decode fields as: opcode [15:12], RegOp1 (destination/source A) [11:8], RegOp2 (source B) [7:4], funct [3:0].
REQ-015 SHALL treat an IF/ID instruction as immediate when opcode is 4..6, or opcode is 0 with funct 8..11; an immediate instruction has no B-source hazard.
REQ-016 SHALL implement states IDLE and MD_BUSY with a 4-bit down-counter cnt.
REQ-017 Load-use detection: SHALL detect when the state is IDLE, IDEX opcode is 8, and IFID RegOp1 equals IDEX RegOp1, or IFID RegOp2 equals IDEX RegOp1 with IFID not immediate.
REQ-018 On a load-use hit with Flush=0, SHALL drive PCWrite=0, IFIDWrite=0, IDEXBubble=1 and IDEXWrite=1 for exactly one cycle; MEM/WB forwarding covers the next cycle.
REQ-019 On a load-use hit with Flush=1, SHALL suppress the stall: all write enables 1, IDEXBubble=0.
REQ-020 In IDLE, with IDEX a mult or div and its cycle count N>=2, SHALL drive PCWrite=0, IFIDWrite=0, IDEXWrite=0, EXMEMBubble=1 and MDBusy=1, load cnt<=N-2, and enter MD_BUSY.
REQ-021 When N=1, SHALL NOT stall and SHALL remain in IDLE.
REQ-022 In MD_BUSY with cnt!=0, SHALL drive the same stall outputs as REQ-020 and decrement cnt.
REQ-023 In MD_BUSY with cnt==0, SHALL release: all write enables 1, both bubbles 0, MDBusy=1, and return to IDLE next edge.
REQ-024 Total EX occupancy SHALL be exactly N cycles, with N-1 stall cycles.
REQ-025 Mult/div detection SHALL take priority over load-use detection; load-use SHALL NOT be evaluated in MD_BUSY.
REQ-026 Flush SHALL be ignored in MD_BUSY.
REQ-027 In IDLE with no hit, SHALL drive all write enables 1, both bubbles 0 and MDBusy=0.
REQ-028 Outputs SHALL be combinational from state, cnt and the inputs; no output register.

Reset
REQ-029 While rst_n=0, SHALL hold state=IDLE, cnt=0 and StallCount=0, including when asserted mid-MD_BUSY; outputs then follow REQ-027 for the present inputs.
REQ-030 On rst_n deassertion, SHALL begin detection at the first rising clk edge.

Configuration
REQ-031 With macro HAZARD_STALL_COUNT_EN defined, SHALL add output StallCount, 16 bits, incremented each cycle that PCWrite=0 and saturating at 16'hFFFF.
REQ-032 Without HAZARD_STALL_COUNT_EN, the StallCount port and its register SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Load-use A: IDEXIR=16'h8300, IFIDIR=16'h0230 -> PCWrite=0, IFIDWrite=0, IDEXBubble=1 for one cycle only.
REQ-034 Immediate filter: IDEXIR=16'h8300, IFIDIR=16'h4130 -> no stall; IFIDIR=16'h4330 -> stall (RegOp1 match).
REQ-035 Div default: IDEXIR=16'h0125 -> MDBusy=1 for 8 cycles, PCWrite=0 for the first 7, release on the 8th.
REQ-036 Mult with MULT_CYCLES=1: IDEXIR=16'h0124 -> no stall, MDBusy=0.
REQ-037 Flush=1 with the REQ-033 hit -> no stall; then rst_n pulsed low on the 3rd cycle of a div -> immediate IDLE, PCWrite=1.
REQ-038 With HAZARD_STALL_COUNT_EN: a div followed by a load-use stall -> StallCount=8.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall control: load-use interlock plus multi-cycle mult/div EX occupancy.
// Optional stall-cycle counter output is enabled by defining HAZARD_STALL_COUNT_EN.
module hazard_stall_unit #(
  parameter int MULT_CYCLES = 2,
  parameter int DIV_CYCLES  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] IFIDIR,
  input  logic [15:0] IDEXIR,
  input  logic        Flush,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXWrite,
  output logic        IDEXBubble,
  output logic        EXMEMBubble,
  output logic        MDBusy
`ifdef HAZARD_STALL_COUNT_EN
  ,
  output logic [15:0] StallCount
`endif
);

  typedef enum logic {IDLE, MD_BUSY} state_t;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [3:0] ifid_op, ifid_a, ifid_b, ifid_fn;
  logic [3:0] idex_op, idex_a, idex_fn;
  logic       is_mult, is_div, md_start, ifid_imm, load_use;
  logic [3:0] md_n;

  assign ifid_op = IFIDIR[15:12];
  assign ifid_a  = IFIDIR[11:8];
  assign ifid_b  = IFIDIR[7:4];
  assign ifid_fn = IFIDIR[3:0];
  assign idex_op = IDEXIR[15:12];
  assign idex_a  = IDEXIR[11:8];
  assign idex_fn = IDEXIR[3:0];

  assign is_mult  = (idex_op == 4'd0) && (idex_fn == 4'd4);
  assign is_div   = (idex_op == 4'd0) && (idex_fn == 4'd5);
  assign md_n     = is_div ? DIV_N : MULT_N;
  // A single-cycle unit never needs to hold the pipeline.
  assign md_start = (is_mult || is_div) && (md_n >= 4'd2);

  assign ifid_imm = ((ifid_op >= 4'd4) && (ifid_op <= 4'd6)) ||
                    ((ifid_op == 4'd0) && (ifid_fn >= 4'd8) && (ifid_fn <= 4'd11));
  assign load_use = (idex_op == 4'd8) &&
                    ((ifid_a == idex_a) || ((ifid_b == idex_a) && !ifid_imm));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (md_start) begin
          state_d = MD_BUSY;
          cnt_d   = md_n - 4'd2;
        end
      end
      MD_BUSY: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IDEXWrite   = 1'b1;
    IDEXBubble  = 1'b0;
    EXMEMBubble = 1'b0;
    MDBusy      = 1'b0;
    // Held in reset the unit looks idle with no hazard, whatever the inputs.
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (md_start) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEXWrite   = 1'b0;
            EXMEMBubble = 1'b1;
            MDBusy      = 1'b1;
          end else if (load_use && !Flush) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
          end
        end
        MD_BUSY: begin
          MDBusy = 1'b1;
          if (cnt_q != 4'd0) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEXWrite   = 1'b0;
            EXMEMBubble = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HAZARD_STALL_COUNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PCWrite && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= 16'd0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign StallCount = stall_cnt_q;
`endif

endmodule
